// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int unsigned DIV_WIDTH_DEFAULT = 4;
   localparam int unsigned DIV_CNT_WIDTH_DEFAULT = $clog2(DIV_WIDTH_DEFAULT);

   // Iteration counter width; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/subtractor_4b.sv
// Combinational A-B with borrow-out; dual of the datapath library adder.
module subtractor_4b #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   always_comb begin
      {borrow, diff} = {1'b0, a} - {1'b0, b};
   end

endmodule

// File: rtl/divider_4b_seq.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per clock.
// Optional DIVIDER_4B_SEQ_EARLY_EXIT_EN: finish in one cycle when dividend < divisor.
module divider_4b_seq
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd_sr;
   logic [WIDTH-1:0] divisor_reg;
   logic [WIDTH-1:0] part_rem;
   logic [WIDTH-1:0] quo_sr;
   logic             dz_flag;

   // The partial remainder only needs WIDTH+1 bits at the subtractor input;
   // the stored value is always below the divisor, so WIDTH bits hold it.
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             borrow;
   logic             unused_trial_msb;

   assign shifted          = {part_rem, dvd_sr[WIDTH-1]};
   assign unused_trial_msb = trial[WIDTH];

   subtractor_4b #(
      .WIDTH(WIDTH + 1)
   ) u_sub (
      .a      (shifted),
      .b      ({1'b0, divisor_reg}),
      .diff   (trial),
      .borrow (borrow)
   );

   // DONE lasts one cycle; results and the done pulse appear as it returns to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         dvd_sr      <= '0;
         divisor_reg <= '0;
         part_rem    <= '0;
         quo_sr      <= '0;
         dz_flag     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  busy        <= 1'b1;
                  dvd_sr      <= dividend;
                  divisor_reg <= divisor;
                  part_rem    <= '0;
                  quo_sr      <= '0;
                  dz_flag     <= 1'b0;
                  div_by_zero <= 1'b0;
                  cnt         <= CW'(WIDTH - 1);
                  if (divisor == '0) begin
                     quo_sr   <= '1;
                     part_rem <= dividend;
                     dz_flag  <= 1'b1;
                     state    <= DONE;
`ifdef DIVIDER_4B_SEQ_EARLY_EXIT_EN
                  end else if (dividend < divisor) begin
                     part_rem <= dividend;
                     state    <= DONE;
`endif
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               dvd_sr <= dvd_sr << 1;
               if (borrow) begin
                  part_rem <= shifted[WIDTH-1:0];
                  quo_sr   <= {quo_sr[WIDTH-2:0], 1'b0};
               end else begin
                  part_rem <= trial[WIDTH-1:0];
                  quo_sr   <= {quo_sr[WIDTH-2:0], 1'b1};
               end
               if (cnt == '0) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               quotient    <= quo_sr;
               remainder   <= part_rem;
               div_by_zero <= dz_flag;
               done        <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_4b_seq.sv
// Directed self-checking bench for divider_4b_seq (WIDTH=4).
module tb_divider_4b_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic       busy;
   logic       done;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

`ifdef DIVIDER_4B_SEQ_EARLY_EXIT_EN
   localparam int EE_LAT = 1;
`else
   localparam int EE_LAT = 5;
`endif

   divider_4b_seq #(
      .WIDTH(4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Issue one request; inj >= 0 pulses a 1/1 start that many cycles after acceptance.
   task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b,
                         input int inj, input int elat, input logic [3:0] eq,
                         input logic [3:0] er, input logic edz);
      int lat;
      int bc;
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0;
      dividend = 4'($urandom);
      divisor = 4'($urandom);
      lat = 0;
      bc = 0;
      while (1) begin
         if (busy) bc++;
         if (done || lat >= 20) break;
         start = (lat == inj);
         if (lat == inj) begin
            dividend = 4'd1;
            divisor = 4'd1;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check({name, ".latency"}, lat, elat);
      check({name, ".quotient"}, quotient, eq);
      check({name, ".remainder"}, remainder, er);
      check({name, ".div_by_zero"}, div_by_zero, edz);
      check({name, ".busy_cycles"}, bc, elat + 1);
      @(negedge clk);
      check({name, ".done_single"}, done, 1'b0);
      check({name, ".busy_clear"}, busy, 1'b0);
      check({name, ".quotient_held"}, quotient, eq);
   endtask

   initial begin
      int seen;
      repeat (2) @(negedge clk);
      check("reset.busy", busy, 0);
      check("reset.done", done, 0);
      check("reset.quotient", quotient, 0);
      check("reset.remainder", remainder, 0);
      check("reset.div_by_zero", div_by_zero, 0);
      rst = 1'b0;

      run_op("13/3", 4'd13, 4'd3, -1, 5, 4'd4, 4'd1, 1'b0);
      run_op("15/1", 4'd15, 4'd1, -1, 5, 4'd15, 4'd0, 1'b0);
      run_op("15/15", 4'd15, 4'd15, -1, 5, 4'd1, 4'd0, 1'b0);
      run_op("7/0", 4'd7, 4'd0, -1, 1, 4'hF, 4'd7, 1'b1);
      run_op("6/2", 4'd6, 4'd2, -1, 5, 4'd3, 4'd0, 1'b0);
      run_op("2/9", 4'd2, 4'd9, -1, EE_LAT, 4'd0, 4'd2, 1'b0);
      run_op("12/5_ignore", 4'd12, 4'd5, 2, 5, 4'd2, 4'd2, 1'b0);

      // Abort mid-run with an asynchronous reset.
      @(negedge clk);
      start = 1'b1; dividend = 4'd14; divisor = 4'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort.busy", busy, 0);
      check("abort.done", done, 0);
      check("abort.quotient", quotient, 0);
      check("abort.remainder", remainder, 0);
      check("abort.div_by_zero", div_by_zero, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("abort.no_done", seen, 0);
      run_op("14/3", 4'd14, 4'd3, -1, 5, 4'd4, 4'd2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
